// File: rtl/seven_seg_demux.sv
// ============================================================================
// Module   : seven_seg_demux
// Purpose  : Receive side of the multiplexed seven-segment link. It reassembles
//            the two-digit frame, decodes both glyphs and supervises strobe timing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_demux #(
    parameter int FREQ   = 20000,
    parameter int MARGIN = 64,
    parameter int CBITS  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  segment,
    input  logic        sig,
    input  logic        clr_err,
    output logic [13:0] both7seg,
    output logic [3:0]  hex_hi,
    output logic [3:0]  hex_lo,
    output logic [1:0]  hex_valid,
    output logic        frame_valid,
    output logic        link_ok,
    output logic        err_glitch
);

    localparam logic [0:0]       c_upper      = 1'b0;
    localparam logic [0:0]       c_lower      = 1'b1;
    localparam logic [CBITS-1:0] c_freq       = CBITS'(FREQ);
    // The timeout fires on the edge where the gap counter reaches FREQ+1+MARGIN.
    localparam logic [CBITS-1:0] c_timeout_m1 = CBITS'(FREQ + MARGIN);

    logic [0:0]       phase_q, phase_d;
    logic [6:0]       stage_q, stage_d;
    logic [CBITS-1:0] gap_q, gap_d;
    logic             prev_sig_q, prev_sig_d;
    logic             first_q, first_d;
    logic [13:0]      both7seg_q, both7seg_d;
    logic [3:0]       hex_hi_q, hex_hi_d;
    logic [3:0]       hex_lo_q, hex_lo_d;
    logic [1:0]       hex_valid_q, hex_valid_d;
    logic             frame_valid_q, frame_valid_d;
    logic             link_ok_q, link_ok_d;
    logic             err_q, err_d;

    logic w_rise, w_wide, w_short, w_accept, w_timeout;
    logic [4:0] w_dec_hi, w_dec_lo;

    // Returns {legal, nibble}; unknown patterns decode to 0 with legal cleared.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F: decode = 5'h10;
            7'h06: decode = 5'h11;
            7'h5B: decode = 5'h12;
            7'h4F: decode = 5'h13;
            7'h66: decode = 5'h14;
            7'h6D: decode = 5'h15;
            7'h7D: decode = 5'h16;
            7'h07: decode = 5'h17;
            7'h7F: decode = 5'h18;
            7'h6F: decode = 5'h19;
            7'h77: decode = 5'h1A;
            7'h7C: decode = 5'h1B;
            7'h39: decode = 5'h1C;
            7'h5E: decode = 5'h1D;
            7'h79: decode = 5'h1E;
            7'h71: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    assign w_dec_hi  = decode(stage_q);
    assign w_dec_lo  = decode(segment);
    assign w_rise    = sig & ~prev_sig_q;
    assign w_wide    = sig & prev_sig_q;
    assign w_short   = w_rise & ~first_q & (gap_q < c_freq);
    assign w_accept  = w_rise & ~w_short;
    assign w_timeout = (gap_q == c_timeout_m1);

    always_comb begin
        phase_d       = phase_q;
        stage_d       = stage_q;
        gap_d         = (gap_q == {CBITS{1'b1}}) ? gap_q : gap_q + CBITS'(1);
        prev_sig_d    = sig;
        first_d       = first_q;
        both7seg_d    = both7seg_q;
        hex_hi_d      = hex_hi_q;
        hex_lo_d      = hex_lo_q;
        hex_valid_d   = hex_valid_q;
        frame_valid_d = 1'b0;
        link_ok_d     = link_ok_q;
        err_d         = err_q;

        // An accepted strobe takes priority over a coincident timeout.
        if (w_accept) begin
            gap_d   = '0;
            first_d = 1'b0;
            if (phase_q == c_upper) begin
                stage_d = segment;
                phase_d = c_lower;
            end else begin
                both7seg_d    = {stage_q, segment};
                hex_hi_d      = w_dec_hi[3:0];
                hex_lo_d      = w_dec_lo[3:0];
                hex_valid_d   = {w_dec_hi[4], w_dec_lo[4]};
                frame_valid_d = 1'b1;
                link_ok_d     = 1'b1;
                phase_d       = c_upper;
            end
        end else if (w_timeout) begin
            link_ok_d = 1'b0;
            phase_d   = c_upper;
            stage_d   = '0;
            first_d   = 1'b1;
        end

        if (clr_err) begin
            err_d = 1'b0;
        end
        if (w_wide || w_short) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q       <= c_upper;
            stage_q       <= '0;
            gap_q         <= '0;
            prev_sig_q    <= 1'b0;
            first_q       <= 1'b1;
            both7seg_q    <= '0;
            hex_hi_q      <= '0;
            hex_lo_q      <= '0;
            hex_valid_q   <= '0;
            frame_valid_q <= 1'b0;
            link_ok_q     <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            stage_q       <= stage_d;
            gap_q         <= gap_d;
            prev_sig_q    <= prev_sig_d;
            first_q       <= first_d;
            both7seg_q    <= both7seg_d;
            hex_hi_q      <= hex_hi_d;
            hex_lo_q      <= hex_lo_d;
            hex_valid_q   <= hex_valid_d;
            frame_valid_q <= frame_valid_d;
            link_ok_q     <= link_ok_d;
            err_q         <= err_d;
        end
    end

    assign both7seg    = both7seg_q;
    assign hex_hi      = hex_hi_q;
    assign hex_lo      = hex_lo_q;
    assign hex_valid   = hex_valid_q;
    assign frame_valid = frame_valid_q;
    assign link_ok     = link_ok_q;
    assign err_glitch  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_demux.sv
// ============================================================================
// Module   : tb_seven_seg_demux
// Purpose  : Scoreboard bench for seven_seg_demux with a glyph-table reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_demux;

    localparam int FREQ   = 4;
    localparam int MARGIN = 2;
    localparam int CBITS  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  segment = '0;
    logic        sig = 1'b0;
    logic        clr_err = 1'b0;
    logic [13:0] both7seg;
    logic [3:0]  hex_hi, hex_lo;
    logic [1:0]  hex_valid;
    logic        frame_valid, link_ok, err_glitch;

    seven_seg_demux #(.FREQ(FREQ), .MARGIN(MARGIN), .CBITS(CBITS)) dut (
        .clk(clk), .rst(rst), .segment(segment), .sig(sig), .clr_err(clr_err),
        .both7seg(both7seg), .hex_hi(hex_hi), .hex_lo(hex_lo), .hex_valid(hex_valid),
        .frame_valid(frame_valid), .link_ok(link_ok), .err_glitch(err_glitch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] word;
        logic [3:0]  hi;
        logic [3:0]  lo;
        logic [1:0]  hv;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_seen = 0;
    int          n_exp = 0;
    logic [13:0] last_word = '0;
    logic [3:0]  last_hi = '0;
    logic [3:0]  last_lo = '0;

    // Glyph i is the segment pattern that displays hex digit i.
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic void ref_decode(input logic [6:0] p, output logic [3:0] n, output logic v);
        n = 4'h0;
        v = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (glyph[i] == p) begin
                n = 4'(i);
                v = 1'b1;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [6:0] u, input logic [6:0] l);
        exp_t e;
        logic vh, vl;
        ref_decode(u, e.hi, vh);
        ref_decode(l, e.lo, vl);
        e.word = {u, l};
        e.hv   = {vh, vl};
        sb.push_back(e);
        n_exp++;
        last_word = e.word;
        last_hi   = e.hi;
        last_lo   = e.lo;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic strobe(input logic [6:0] p);
        @(posedge clk);
        #1 sig = 1'b1;
        segment = p;
        @(posedge clk);
        #1 sig = 1'b0;
        segment = 7'($urandom);
    endtask

    task automatic wide_strobe(input logic [6:0] p);
        @(posedge clk);
        #1 sig = 1'b1;
        segment = p;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 sig = 1'b0;
    endtask

    task automatic send_frame(input logic [6:0] u, input logic [6:0] l, input int mid, input int post);
        strobe(u);
        idle(mid);
        push_frame(u, l);
        strobe(l);
        idle(post);
    endtask

    task automatic clear_err();
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        check("err_cleared", 32'(err_glitch), 32'd0);
    endtask

    function automatic logic [6:0] rand_pat();
        if ($urandom_range(0, 3) == 0) return 7'($urandom);
        return glyph[$urandom_range(0, 15)];
    endfunction

    // Monitor: every frame_valid pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst && frame_valid === 1'b1) begin
            n_seen++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame: got both7seg=0x%0h expected no frame", both7seg);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("both7seg", 32'(both7seg), 32'(e.word));
                check("hex_hi", 32'(hex_hi), 32'(e.hi));
                check("hex_lo", 32'(hex_lo), 32'(e.lo));
                check("hex_valid", 32'(hex_valid), 32'(e.hv));
                check("link_ok_on_frame", 32'(link_ok), 32'd1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [6:0] u, l;

        repeat (2) @(posedge clk);
        #1;
        check("rst_both7seg", 32'(both7seg), 32'd0);
        check("rst_hex", 32'({hex_hi, hex_lo, hex_valid}), 32'd0);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_link_ok", 32'(link_ok), 32'd0);
        check("rst_err", 32'(err_glitch), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        send_frame(7'h06, 7'h4F, FREQ - 1, FREQ - 1);
        check("t1_link_ok", 32'(link_ok), 32'd1);
        check("t1_err", 32'(err_glitch), 32'd0);

        send_frame(7'h7F, 7'h71, FREQ - 1, FREQ - 1);
        send_frame(7'h77, 7'h5E, FREQ - 1, FREQ - 1);
        send_frame(7'h00, 7'h3F, FREQ - 1, FREQ - 1);

        for (int i = 0; i < 24; i++) begin
            u = rand_pat();
            l = rand_pat();
            send_frame(u, l, FREQ - 1 + int'($urandom_range(0, MARGIN)),
                       FREQ - 1 + int'($urandom_range(0, MARGIN)));
        end
        check("rand_err", 32'(err_glitch), 32'd0);
        check("rand_link_ok", 32'(link_ok), 32'd1);

        // Over-wide strobe: first cycle is the upper digit, second cycle is an error.
        wide_strobe(7'h07);
        idle(FREQ - 2);
        push_frame(7'h07, 7'h6F);
        strobe(7'h6F);
        idle(FREQ - 1);
        check("wide_err", 32'(err_glitch), 32'd1);
        clear_err();
        idle(FREQ);

        // Early strobe between upper and lower must be ignored.
        strobe(7'h39);
        strobe(7'h79);
        idle(1);
        push_frame(7'h39, 7'h7C);
        strobe(7'h7C);
        idle(FREQ - 1);
        check("short_err", 32'(err_glitch), 32'd1);
        clear_err();
        idle(FREQ);

        // Watchdog timeout after the last strobe.
        send_frame(7'h66, 7'h6D, FREQ - 1, 0);
        repeat (FREQ + MARGIN) @(posedge clk);
        #1 check("link_ok_before_timeout", 32'(link_ok), 32'd1);
        @(posedge clk);
        #1 check("link_ok_after_timeout", 32'(link_ok), 32'd0);
        check("hold_both7seg", 32'(both7seg), 32'(last_word));
        check("hold_hex", 32'({hex_hi, hex_lo}), 32'({last_hi, last_lo}));
        idle(3);

        send_frame(7'h5B, 7'h66, FREQ - 1, FREQ - 1);
        check("resume_link_ok", 32'(link_ok), 32'd1);
        check("resume_err", 32'(err_glitch), 32'd0);
        check("resume_word", 32'(both7seg), 32'h2DE6);

        // Asynchronous reset between the upper and lower strobes.
        strobe(7'h4F);
        #2 rst = 1'b0;
        #1;
        check("arst_both7seg", 32'(both7seg), 32'd0);
        check("arst_hex", 32'({hex_hi, hex_lo, hex_valid}), 32'd0);
        check("arst_link_ok", 32'(link_ok), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        send_frame(7'h6D, 7'h7D, FREQ - 1, FREQ - 1);
        check("post_rst_word", 32'(both7seg), 32'h36FD);
        check("post_rst_hex", 32'({hex_hi, hex_lo}), 32'h56);

        idle(4);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("frame_count", 32'(n_seen), 32'(n_exp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
